// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared sizes and source index constants for the writeback result arbiter.
//   N_SRC  : number of result sources sharing the register-file write port
//   SEL_W  : width of the result mux select
//   REG_W  : register index width
//   XLEN   : datapath width
// rd_of() extracts the 5-bit destination register of one source from the
// flattened rd bus (source i at [5i+4:5i]).
// ---------------------------------------------------------------------------
package wb_arb_pkg;
  localparam int N_SRC = 8;
  localparam int SEL_W = 3;
  localparam int REG_W = 5;
  localparam int XLEN  = 32;

  localparam logic [SEL_W-1:0] SRC_ALU    = 3'd0;
  localparam logic [SEL_W-1:0] SRC_LOAD   = 3'd1;
  localparam logic [SEL_W-1:0] SRC_PC4    = 3'd2;
  localparam logic [SEL_W-1:0] SRC_UIMM   = 3'd3;
  localparam logic [SEL_W-1:0] SRC_MULDIV = 3'd4;
  localparam logic [SEL_W-1:0] SRC_CSR    = 3'd5;
  localparam logic [SEL_W-1:0] SRC_SPARE6 = 3'd6;
  localparam logic [SEL_W-1:0] SRC_SPARE7 = 3'd7;

  function automatic logic [REG_W-1:0] rd_of(input logic [N_SRC*REG_W-1:0] flat,
                                             input logic [SEL_W-1:0]       idx);
    return flat[idx*REG_W +: REG_W];
  endfunction
endpackage

// File: rtl/wb_result_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_result_arbiter_if
// Bundles the source-side handshake, the result mux select and the
// registered writeback slot.
//   master : the sources / pipeline side (drives req, rd_flat, stall,
//            result_in; observes grant, sel and the wb_* slot)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface wb_result_arbiter_if;
  import wb_arb_pkg::*;

  logic [N_SRC-1:0]       req;
  logic [N_SRC*REG_W-1:0] rd_flat;
  logic                   stall;
  logic [XLEN-1:0]        result_in;
  logic [N_SRC-1:0]       grant;
  logic [SEL_W-1:0]       sel;
  logic                   wb_valid;
  logic [REG_W-1:0]       wb_rd;
  logic                   wb_we;
  logic [XLEN-1:0]        wb_data;

  modport master (
    output req, rd_flat, stall, result_in,
    input  grant, sel, wb_valid, wb_rd, wb_we, wb_data
  );

  modport slave (
    input  req, rd_flat, stall, result_in,
    output grant, sel, wb_valid, wb_rd, wb_we, wb_data
  );
endinterface

// File: rtl/wb_result_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Rotating priority encoder. Scans vec starting at ptr+1 and wrapping 7->0;
// the first set bit wins. With ptr=7 it degenerates to a plain
// lowest-index-first encoder.
//   vec   : candidate vector
//   ptr   : last winner; scan starts one above it
//   pick  : one-hot winner (all zero when vec is empty)
//   idx   : binary index of the winner (0 when none)
//   found : vec had at least one bit set
// ---------------------------------------------------------------------------
module rr_pick
  import wb_arb_pkg::*;
(
  input  logic [N_SRC-1:0] vec,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_SRC-1:0] pick,
  output logic [SEL_W-1:0] idx,
  output logic             found
);
  logic [SEL_W-1:0] cand;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // k+1 wraps to 0 on the last step, so ptr itself is scanned last.
    for (int k = 0; k < N_SRC; k++) begin
      cand = ptr + SEL_W'(k + 1);
      if (!found && vec[cand]) begin
        found      = 1'b1;
        idx        = cand;
        pick[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_result_arbiter.sv
// ---------------------------------------------------------------------------
// wb_result_arbiter
// Shares the single register-file write port among 8 result sources.
// Each cycle with stall low it grants at most one requester, drives the
// result mux select, and registers {result, rd, we} into the writeback slot.
// Grant order: (optional) starved source, then PRIO_MASK sources lowest index
// first, then round-robin among the rest starting after rr_ptr.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of wb_result_arbiter_if
// Optional feature macro WB_STARVE_GUARD_EN: per-source wait counters; a
// source that has waited MAX_WAIT cycles overrides PRIO_MASK.
// ---------------------------------------------------------------------------
module wb_result_arbiter
  import wb_arb_pkg::*;
#(
  parameter logic [N_SRC-1:0] PRIO_MASK = 8'b0000_0001
`ifdef WB_STARVE_GUARD_EN
  ,
  parameter int               MAX_WAIT  = 15
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_result_arbiter_if.slave  bus
);
  logic [N_SRC-1:0] prio_pick, rr_pick_vec, grant_c;
  logic [SEL_W-1:0] prio_idx, rr_idx, sel_c;
  logic             prio_found, rr_found;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             wb_valid_q, wb_valid_d;
  logic [REG_W-1:0] wb_rd_q, wb_rd_d;
  logic             wb_we_q, wb_we_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic [REG_W-1:0] rd_sel;

  rr_pick u_prio (
    .vec   (bus.req & PRIO_MASK),
    .ptr   (3'd7),
    .pick  (prio_pick),
    .idx   (prio_idx),
    .found (prio_found)
  );

  rr_pick u_rr (
    .vec   (bus.req & ~PRIO_MASK),
    .ptr   (rr_ptr_q),
    .pick  (rr_pick_vec),
    .idx   (rr_idx),
    .found (rr_found)
  );

`ifdef WB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [N_SRC-1:0] sat_vec, starve_pick;
  logic [SEL_W-1:0] starve_idx;
  logic             starve_found;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_wait
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Waiting is only counted on cycles the port was actually available.
      always_comb begin
        cnt_d = cnt_q;
        if (!bus.req[gi] || grant_c[gi]) begin
          cnt_d = '0;
        end else if (!bus.stall && cnt_q != CNT_W'(MAX_WAIT)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end

      assign sat_vec[gi] = bus.req[gi] && (cnt_q == CNT_W'(MAX_WAIT));
    end
  endgenerate

  rr_pick u_starve (
    .vec   (sat_vec),
    .ptr   (3'd7),
    .pick  (starve_pick),
    .idx   (starve_idx),
    .found (starve_found)
  );
`endif

  // Arbitration. rst_n gates the grant so an in-flight grant vanishes as soon
  // as reset asserts, without waiting for an edge.
  always_comb begin
    grant_c  = '0;
    sel_c    = '0;
    rr_ptr_d = rr_ptr_q;
    if (rst_n && !bus.stall) begin
`ifdef WB_STARVE_GUARD_EN
      if (starve_found) begin
        grant_c = starve_pick;
        sel_c   = starve_idx;
      end else
`endif
      if (prio_found) begin
        grant_c = prio_pick;
        sel_c   = prio_idx;
      end else if (rr_found) begin
        grant_c  = rr_pick_vec;
        sel_c    = rr_idx;
        rr_ptr_d = rr_idx;
      end
    end
  end

  assign rd_sel = rd_of(bus.rd_flat, sel_c);

  // Writeback slot: frozen under stall; on an idle cycle only valid/we drop.
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    wb_data_d  = wb_data_q;
    if (!bus.stall) begin
      if (|grant_c) begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_sel;
        wb_we_d    = (rd_sel != '0);
        wb_data_d  = bus.result_in;
      end else begin
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= 3'd7;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign bus.grant    = grant_c;
  assign bus.sel      = sel_c;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_we    = wb_we_q;
  assign bus.wb_data  = wb_data_q;
endmodule

// File: tb/tb_wb_result_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_result_arbiter
// Directed bench for wb_result_arbiter with hand-computed expectations.
// Source i drives rd/data from a fixed table; result_in is modelled as the
// 8:1 mux indexed by the DUT's sel.
//   rd   : src0=5 src1=7 src2=0 src3=9 src4=11 src5=13 src6=15 src7=31
//   data : src i = 32'hA000_000i, except src2 = 32'hDEAD_BEEF
// ---------------------------------------------------------------------------
module tb_wb_result_arbiter;
  logic clk = 1'b0;
  logic rst_n;

  wb_result_arbiter_if bus ();

  wb_result_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] src_data [8];
  assign bus.result_in = src_data[bus.sel];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %-14s got=%08h expected=%08h @%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %-14s value=%08h @%0t", tag, got, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    bus.req   = '0;
    bus.stall = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  int          rr_idx  [5] = '{1, 2, 4, 5, 1};
  logic [4:0]  rr_rd   [5] = '{5'd7, 5'd0, 5'd11, 5'd13, 5'd7};
  logic        rr_we   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [31:0] rr_data [5] = '{32'hA000_0001, 32'hDEAD_BEEF, 32'hA000_0004,
                               32'hA000_0005, 32'hA000_0001};

  initial begin
    for (int i = 0; i < 8; i++) src_data[i] = 32'hA000_0000 | 32'(i);
    src_data[2] = 32'hDEAD_BEEF;
    bus.rd_flat = {5'd31, 5'd15, 5'd13, 5'd11, 5'd9, 5'd0, 5'd7, 5'd5};

    // Reset held with every source requesting.
    rst_n     = 1'b0;
    bus.stall = 1'b0;
    bus.req   = 8'hFF;
    repeat (3) tick();
    mid();
    check_eq("rst_grant", 32'(bus.grant), 32'h0);
    check_eq("rst_valid", 32'(bus.wb_valid), 32'h0);
    check_eq("rst_we", 32'(bus.wb_we), 32'h0);
    check_eq("rst_rd", 32'(bus.wb_rd), 32'h0);
    check_eq("rst_data", bus.wb_data, 32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("rel_grant", 32'(bus.grant), 32'h01);
    check_eq("rel_sel", 32'(bus.sel), 32'h0);
    tick();
    check_eq("rel_wb_valid", 32'(bus.wb_valid), 32'h1);
    check_eq("rel_wb_rd", 32'(bus.wb_rd), 32'd5);
    check_eq("rel_wb_we", 32'(bus.wb_we), 32'h1);
    check_eq("rel_wb_data", bus.wb_data, 32'hA000_0000);
    // Idle cycle: valid/we drop, rd/data hold.
    bus.req = '0;
    tick();
    check_eq("idle_valid", 32'(bus.wb_valid), 32'h0);
    check_eq("idle_we", 32'(bus.wb_we), 32'h0);
    check_eq("idle_rd", 32'(bus.wb_rd), 32'd5);
    check_eq("idle_data", bus.wb_data, 32'hA000_0000);

    // Round-robin among non-priority sources, includes x0 source 2.
    do_reset();
    bus.req = 8'b0011_0110;
    for (int k = 0; k < 5; k++) begin
      mid();
      check_eq("rr_grant", 32'(bus.grant), 32'h1 << rr_idx[k]);
      check_eq("rr_sel", 32'(bus.sel), 32'(rr_idx[k]));
      tick();
      check_eq("rr_wb_valid", 32'(bus.wb_valid), 32'h1);
      check_eq("rr_wb_rd", 32'(bus.wb_rd), 32'(rr_rd[k]));
      check_eq("rr_wb_we", 32'(bus.wb_we), 32'(rr_we[k]));
      check_eq("rr_wb_data", bus.wb_data, rr_data[k]);
    end

    // Fixed priority source 0 against round-robin source 3.
    do_reset();
    bus.req = 8'b0000_1001;
    for (int c = 1; c <= 16; c++) begin
      mid();
`ifdef WB_STARVE_GUARD_EN
      check_eq("prio_grant", 32'(bus.grant), (c == 16) ? 32'h08 : 32'h01);
`else
      check_eq("prio_grant", 32'(bus.grant), 32'h01);
`endif
      tick();
    end

    // Stall freezes the slot; held request granted as soon as it drops.
    do_reset();
    bus.req = 8'b0000_0010;
    mid();
    check_eq("pre_stall_gnt", 32'(bus.grant), 32'h02);
    tick();
    bus.req   = 8'b0001_0000;
    bus.stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      mid();
      check_eq("stall_grant", 32'(bus.grant), 32'h0);
      check_eq("stall_sel", 32'(bus.sel), 32'h0);
      tick();
      check_eq("stall_valid", 32'(bus.wb_valid), 32'h1);
      check_eq("stall_rd", 32'(bus.wb_rd), 32'd7);
      check_eq("stall_data", bus.wb_data, 32'hA000_0001);
    end
    bus.stall = 1'b0;
    #1;
    check_eq("unstall_grant", 32'(bus.grant), 32'h10);
    check_eq("unstall_sel", 32'(bus.sel), 32'd4);
    tick();
    check_eq("unstall_valid", 32'(bus.wb_valid), 32'h1);
    check_eq("unstall_rd", 32'(bus.wb_rd), 32'd11);
    check_eq("unstall_data", bus.wb_data, 32'hA000_0004);
    bus.req = '0;
    tick();
    check_eq("drain_valid", 32'(bus.wb_valid), 32'h0);
    check_eq("drain_rd", 32'(bus.wb_rd), 32'd11);

    // Asynchronous reset between edges while source 1 is granted.
    do_reset();
    bus.req = 8'b0000_0010;
    tick();
    mid();
    check_eq("pre_ar_grant", 32'(bus.grant), 32'h02);
    check_eq("pre_ar_valid", 32'(bus.wb_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_grant", 32'(bus.grant), 32'h0);
    check_eq("ar_valid", 32'(bus.wb_valid), 32'h0);
    check_eq("ar_data", bus.wb_data, 32'h0);
    tick();
    check_eq("ar_hold_valid", 32'(bus.wb_valid), 32'h0);
    rst_n = 1'b1;
    #1;
    check_eq("ar_regrant", 32'(bus.grant), 32'h02);
    tick();
    check_eq("ar_wb_valid", 32'(bus.wb_valid), 32'h1);
    check_eq("ar_wb_rd", 32'(bus.wb_rd), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_result_arbiter.md
Name: wb_result_arbiter

Overview:
- Shares the single register-file write port among up to 8 result sources: ALU, load, PC+4, LUI/AUIPC, mul/div, CSR, and spares.
- Sources request with a req/grant handshake. The block drives the 3-bit select of the 8:1 writeback result mux.
- It registers the selected result, rd and write-enable into the writeback stage.
- Sits between the execute/memory functional units and the register file, downstream of the result mux.

Parameters:
- N_SRC, 8, number of result sources; fixed at 8 to match the mux select width.
- PRIO_MASK, 8'b0000_0001, sources that win over round-robin (fixed priority, lowest index first).
- MAX_WAIT, 15, starvation threshold in cycles; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  8  per-source request; held until granted
- rd_flat  in  40  destination register per source; rd of source i at [5i+4:5i]
- stall  in  1  write port busy; no grants issued, writeback registers hold
- result_in  in  32  output of the result mux, selected by sel
- grant  out  8  one-hot accept; a transfer occurs when req[i] & grant[i]
- sel  out  3  mux select = index of granted source; 0 when no grant
- wb_valid  out  1  registered: writeback slot holds a transfer
- wb_rd  out  5  registered destination register
- wb_we  out  1  registered write enable; 0 when rd == 0
- wb_data  out  32  registered result

Behaviour:
- Reset (async, rst_n low):
  - grant=0, wb_valid=0, wb_rd=0, wb_we=0, wb_data=0.
  - Internal rr_ptr=7, so the first round-robin scan starts at source 0.
  - All wait counters cleared.
  - Reset mid-transfer discards the in-flight grant; sources keep req asserted and are re-arbitrated after reset.
- Arbitration (combinational, cycle T; only when stall=0):
  - 1. With WB_STARVE_GUARD_EN: the lowest-index source whose counter equals MAX_WAIT wins.
  - 2. Otherwise, the lowest-index requesting source in PRIO_MASK wins.
  - 3. Otherwise, round-robin among the remaining requesters, scanning from rr_ptr+1 with wrap 7->0.
- Outputs in cycle T:
  - At most one grant bit high.
  - sel = binary index of the granted source, so result_in is valid in the same cycle T.
  - rr_ptr updates to the granted index only on a step-3 grant.
- Latency: data is captured at the end of T and appears on the wb_* outputs in T+1, i.e. one cycle.
  - wb_valid=1, wb_rd=rd of the granted source, wb_we=(rd!=0), wb_data=result_in.
- No grant and stall=0: wb_valid=0 and wb_we=0 next cycle; wb_rd/wb_data hold their last values.
- stall=1: grant=0, sel=0, all wb_* registers hold.
  - A req arriving during stall waits; it is never dropped.
- A req that falls without a grant is legal (source flush). Its wait counter clears.
- A single requester is granted in the same cycle, with no bubble.
- Back-to-back grants to different sources give one transfer per cycle.

Optional Feature:
- Macro: WB_STARVE_GUARD_EN.
- Defined:
  - Each source has a wait counter of width $clog2(MAX_WAIT+1).
  - The counter increments while req[i]=1, grant[i]=0 and stall=0, saturating at MAX_WAIT.
  - It clears on grant or when req[i]=0.
  - A saturated source overrides PRIO_MASK (step 1).
- Undefined: no counters, no step 1; PRIO_MASK sources can starve round-robin sources indefinitely.

Decomposition:
- Package wb_arb_pkg holds:
  - N_SRC=8, SEL_W=3, REG_W=5, XLEN=32.
  - Source index constants: SRC_ALU=0, SRC_LOAD=1, SRC_PC4=2, SRC_UIMM=3, SRC_MULDIV=4, SRC_CSR=5, SRC_SPARE6=6, SRC_SPARE7=7.
- One sub-module, rr_pick: rotating priority encoder taking (vec[7:0], ptr[2:0]) and returning a one-hot pick and its index. It is reused for the masked-priority scan with ptr=7.

Test Plan:
- Reset: hold rst_n=0 with req=8'hFF -> grant=0, wb_valid=0, wb_we=0. Release -> source 0 granted first (PRIO_MASK), sel=0.
- Round-robin: req=8'b0011_0110 held, sources re-request after each grant, PRIO_MASK=0 -> grant order 1,2,4,5,1; wb_data equals the mux input of each source one cycle later.
- Priority: req[0] held with req[3]=1 -> source 0 granted every cycle, source 3 never (feature off). Feature on with MAX_WAIT=15 -> source 3 granted on cycle 16.
- x0 suppression: source 2 with rd=0 granted, result_in=32'hDEAD_BEEF -> wb_valid=1, wb_we=0, wb_rd=0.
- Stall: stall=1 for 3 cycles with req[4]=1 -> grant=0 and wb_* frozen. Stall drops -> grant[4]=1 the same cycle, wb_valid=1 the next.
- Async reset mid-operation: rst_n low between edges while grant[1]=1 -> outputs clear immediately; wb_valid never shows that transfer.
